// File: rtl/sync_edge_detector.sv
// Multi-flop synchronizer for one asynchronous bit plus single-cycle edge pulses.
// Define SYNC_EDGE_DETECTOR_REGISTERED_OUTPUTS_EN to register the edge outputs (one extra cycle).
module sync_edge_detector #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_low,
  input  logic bit_in,
  output logic level,
  output logic pos_edge,
  output logic neg_edge,
  output logic any_edge
);

  generate
    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
      $error("sync_edge_detector: STAGES must be in 2..8");
    end
  endgenerate

  // Pure flop-to-flop chain so the tools can place the stages back to back.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] s;
  logic prev;
  logic pos_c, neg_c, any_c;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      s    <= {STAGES{RESET_VALUE}};
      prev <= RESET_VALUE;
    end else begin
      s    <= {s[STAGES-2:0], bit_in};
      prev <= s[STAGES-1];
    end
  end

  assign level = s[STAGES-1];
  assign pos_c = level & ~prev;
  assign neg_c = ~level & prev;
  assign any_c = level ^ prev;

`ifdef SYNC_EDGE_DETECTOR_REGISTERED_OUTPUTS_EN
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      any_edge <= 1'b0;
    end else begin
      pos_edge <= pos_c;
      neg_edge <= neg_c;
      any_edge <= any_c;
    end
  end
`else
  assign pos_edge = pos_c;
  assign neg_edge = neg_c;
  assign any_edge = any_c;
`endif

endmodule

// File: tb/tb_sync_edge_detector.sv
// Directed bench for sync_edge_detector: STAGES=2 and STAGES=3 instances share inputs.
module tb_sync_edge_detector;
`ifdef SYNC_EDGE_DETECTOR_REGISTERED_OUTPUTS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset_low = 1'b0;
  logic bit_in = 1'b0;
  logic l2, p2, n2, a2;
  logic l3, p3, n3, a3;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_edge_detector #(.STAGES(2), .RESET_VALUE(1'b0)) dut2 (
    .clk(clk), .reset_low(reset_low), .bit_in(bit_in),
    .level(l2), .pos_edge(p2), .neg_edge(n2), .any_edge(a2)
  );

  sync_edge_detector #(.STAGES(3), .RESET_VALUE(1'b0)) dut3 (
    .clk(clk), .reset_low(reset_low), .bit_in(bit_in),
    .level(l3), .pos_edge(p3), .neg_edge(n3), .any_edge(a3)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_l2"}, l2, 1'b0);
    chk({tag, "_e2"}, p2 | n2 | a2, 1'b0);
    chk({tag, "_l3"}, l3, 1'b0);
    chk({tag, "_e3"}, p3 | n3 | a3, 1'b0);
  endtask

  int cnt_any, cnt_pos, cnt_neg, first_any, last_any, overlap, mism;

  initial begin
    // Reset held with bit_in high: nothing may leak through.
    reset_low = 1'b0;
    bit_in    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      all_zero("in_reset");
    end

    // Release just after an edge; first post-release edge must be quiet.
    reset_low = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("rel_l2_n%0d", n), l2, n >= 2);
      chk($sformatf("rel_p2_n%0d", n), p2, n == 2 + LAT);
      chk($sformatf("rel_a2_n%0d", n), a2, n == 2 + LAT);
      chk($sformatf("rel_n2_n%0d", n), n2, 1'b0);
      chk($sformatf("rel_l3_n%0d", n), l3, n >= 3);
      chk($sformatf("rel_p3_n%0d", n), p3, n == 3 + LAT);
    end

    // Falling transition.
    bit_in = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("fall_l2_n%0d", n), l2, n < 2);
      chk($sformatf("fall_n2_n%0d", n), n2, n == 2 + LAT);
      chk($sformatf("fall_a2_n%0d", n), a2, n == 2 + LAT);
      chk($sformatf("fall_p2_n%0d", n), p2, 1'b0);
      chk($sformatf("fall_n3_n%0d", n), n3, n == 3 + LAT);
      chk($sformatf("fall_a3_n%0d", n), a3, n == 3 + LAT);
    end

    // Rising transition from a quiet steady state.
    bit_in = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk($sformatf("rise_p2_n%0d", n), p2, n == 2 + LAT);
      chk($sformatf("rise_n2_n%0d", n), n2, 1'b0);
      chk($sformatf("rise_p3_n%0d", n), p3, n == 3 + LAT);
    end
    bit_in = 1'b0;
    for (int n = 0; n < 6; n++) step();
    all_zero("settled");

    // Toggle every cycle for 8 cycles, then hold.
    cnt_any = 0; cnt_pos = 0; cnt_neg = 0;
    first_any = -1; last_any = -1; overlap = 0; mism = 0;
    for (int n = 0; n < 16; n++) begin
      if (n < 8) bit_in = ~bit_in;
      step();
      if (a2) begin
        cnt_any++;
        if (first_any < 0) first_any = n;
        last_any = n;
      end
      if (p2) cnt_pos++;
      if (n2) cnt_neg++;
      if (p2 & n2) overlap++;
      if (a2 !== (p2 | n2)) mism++;
    end
    chki("tog_any_cnt", cnt_any, 8);
    chki("tog_pos_cnt", cnt_pos, 4);
    chki("tog_neg_cnt", cnt_neg, 4);
    chki("tog_any_span", last_any - first_any + 1, 8);
    chki("tog_first", first_any, 1 + LAT);
    chki("tog_overlap", overlap, 0);
    chki("tog_any_or", mism, 0);
    chk("tog_end_level", l2, 1'b0);

    // Mid-cycle reset while a rising transition sits inside the chain.
    bit_in = 1'b1;
    step();
    #3;
    reset_low = 1'b0;
    #1;
    all_zero("async_rst");
    step();
    all_zero("async_rst_hold");
    reset_low = 1'b1;
    cnt_pos = 0; cnt_neg = 0;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("rerel_p2_n%0d", n), p2, n == 2 + LAT);
      if (p2) cnt_pos++;
      if (n2) cnt_neg++;
    end
    chki("rerel_pos_cnt", cnt_pos, 1);
    chki("rerel_neg_cnt", cnt_neg, 0);
    chk("rerel_level", l2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_edge_detector.md
Name: sync_edge_detector

Overview:
- Brings one asynchronous input bit into the `clk` domain through a multi-flop synchronizer, then detects transitions on the synchronized level.
- Produces the clean synchronized level plus single-cycle rising, falling and any-edge pulses.
- Sits at the front of input-conditioning logic such as debouncers and button/strobe handlers.

Parameters:
- STAGES, 2, number of synchronizer flops in series; legal range 2..8; any other value is an elaboration error.
- RESET_VALUE, 1'b0, level loaded into every synchronizer flop and the edge history register on reset.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_low  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to `clk` (deasserted by an upstream reset synchronizer).
- bit_in  input  1  asynchronous input; no timing relationship to `clk`.
- level  output  1  synchronized level: output of the last synchronizer stage.
- pos_edge  output  1  high for exactly one cycle when `level` goes 0->1.
- neg_edge  output  1  high for exactly one cycle when `level` goes 1->0.
- any_edge  output  1  `pos_edge` OR `neg_edge`.

Behaviour:
- Synchronizer:
  - Shift chain `s[0..STAGES-1]`; each rising `clk` does `s[0] <= bit_in`, `s[i] <= s[i-1]`.
  - `level = s[STAGES-1]`.
  - No logic between stages.
  - Stage flops carry the synthesis attribute `ASYNC_REG = "TRUE"`.
- Edge history: `prev <= level` every rising `clk`.
- Edge outputs, combinational from registers only (no path from `bit_in`):
  - `pos_edge = level & ~prev`
  - `neg_edge = ~level & prev`
  - `any_edge = level ^ prev`
- Reset (`reset_low` = 0), asynchronous: all `s[i]` and `prev` go to RESET_VALUE.
  - Therefore `level` = RESET_VALUE and `pos_edge`, `neg_edge`, `any_edge` = 0 while in reset and on the first cycle after release.
  - No spurious edge is ever produced by reset entry or exit.
- Latency:
  - `bit_in` stable across rising edge k is seen on `level` after edge k+STAGES-1.
  - The corresponding edge pulse is high in the cycle between edges k+STAGES-1 and k+STAGES.
  - STAGES=2: 2 clock edges from the sampling edge to the end of the pulse.
- Pulse width: exactly 1 cycle for every level change.
- Input pulse shorter than one clock period: may or may not be captured; if captured, it yields one pos_edge followed by one neg_edge, never overlapping.
- Input toggling every cycle: `level` follows with latency; `any_edge` is high every cycle; `pos_edge` and `neg_edge` alternate.
- `bit_in` held constant: all edge outputs remain 0 indefinitely.
- Reset asserted mid-operation:
  - Any pending transition inside the chain is discarded.
  - After release, the chain refills from `bit_in`.
  - If `bit_in` differs from RESET_VALUE, exactly one edge pulse appears STAGES cycles after release.
- Initial values (FPGA power-up) equal the reset values.

Optional Feature:
- Macro: SYNC_EDGE_DETECTOR_REGISTERED_OUTPUTS_EN.
- When defined:
  - `pos_edge`, `neg_edge` and `any_edge` are driven from flops loaded with the combinational equations above.
  - Pulses are delayed by one extra cycle, still exactly one cycle wide, and reset asynchronously to 0.
  - `level` is unchanged.
- When undefined: outputs are combinational as specified (default).

Test Plan:
- Reset held low, `bit_in`=1 -> `level`=0 and all edges 0 throughout reset. Release -> with STAGES=2, `pos_edge`=1 for exactly one cycle 2 cycles after release; `level`=1 thereafter.
- After reset, `bit_in` 0->1 ahead of edge k -> `level`=1 after edge k+1; `pos_edge`=`any_edge`=1 only between edges k+1 and k+2; `neg_edge` stays 0.
- `bit_in` 1->0 -> single `neg_edge`/`any_edge` pulse with the same 2-cycle latency; `pos_edge` stays 0.
- `bit_in` toggled every cycle for 8 cycles (STAGES=2) -> `any_edge` high 8 consecutive cycles; `pos_edge`/`neg_edge` alternate 4 each.
- STAGES=3, `bit_in` 0->1 -> pulse appears one cycle later than with STAGES=2. With SYNC_EDGE_DETECTOR_REGISTERED_OUTPUTS_EN defined -> one further cycle, width still 1.
- `reset_low` pulsed low asynchronously (mid-cycle) while a transition is in the chain -> outputs clear immediately with no pulse; after release, exactly one pulse if `bit_in` != RESET_VALUE.
